// File: rtl/sp_ram_pkg.sv
// Shared types and default parameters for the banked single-port RAM.
// Bank power states are used when SP_RAM_SLEEP_EN is defined.
package sp_ram_pkg;

  localparam int unsigned DEF_RAM_SIZE    = 32768;
  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_NUM_BANKS   = 8;
  localparam int unsigned DEF_IDLE_CYCLES = 16;
  localparam int unsigned DEF_WAKE_CYCLES = 2;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } bank_state_e;

  // Counter/select width that never collapses to zero bits
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sp_ram_bank_pm.sv
// One RAM bank: word storage with byte-enable writes plus its power FSM.
// The SLEEP/WAKE FSM and its counters exist only when SP_RAM_SLEEP_EN is defined.
module sp_ram_bank_pm
  import sp_ram_pkg::*;
#(
  parameter int unsigned WORDS       = 1024,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
  localparam int unsigned IDX_W      = width_of(WORDS),
  localparam int unsigned BE_W       = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  acc_i,
  input  logic                  we_i,
  input  logic [BE_W-1:0]       be_i,
  input  logic [IDX_W-1:0]      word_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_c,
  output logic                  active_c,
  output logic                  sleep_c
);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Storage has no reset so contents survive reset and sleep
  always_ff @(posedge clk) begin
    if (acc_i && we_i) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be_i[b]) mem[word_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_c = mem[word_i];

`ifdef SP_RAM_SLEEP_EN
  localparam int unsigned IDLE_W = width_of(IDLE_CYCLES);
  localparam int unsigned WAKE_W = width_of(WAKE_CYCLES);

  bank_state_e       state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [WAKE_W-1:0] wake_q, wake_d;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= ACTIVE;
      idle_q  <= '0;
      wake_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wake_q  <= wake_d;
    end
  end

  // An access always beats idle expiry in the same cycle
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    case (state_q)
      ACTIVE: begin
        if (acc_i) begin
          idle_d = '0;
        end else if (IDLE_CYCLES != 0) begin
          if (idle_q == IDLE_W'(IDLE_CYCLES - 1)) begin
            state_d = SLEEP;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
      SLEEP: begin
        if (req_i) begin
          state_d = WAKE;
          wake_d  = '0;
        end
      end
      WAKE: begin
        if (wake_q == WAKE_W'(WAKE_CYCLES - 1)) begin
          state_d = ACTIVE;
          idle_d  = '0;
          wake_d  = '0;
        end else begin
          wake_d = wake_q + WAKE_W'(1);
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  assign active_c = (state_q == ACTIVE);
  assign sleep_c  = (state_q == SLEEP);
`else
  logic unused_pm;
  assign unused_pm = ^{rst_i, req_i};
  assign active_c  = 1'b1;
  assign sleep_c   = 1'b0;
`endif

endmodule

// File: rtl/sp_ram_banked.sv
// Banked single-port RAM with per-bank sleep, one-cycle response latency.
// Define SP_RAM_SLEEP_EN to compile in the per-bank SLEEP/WAKE power management.
module sp_ram_banked
  import sp_ram_pkg::*;
#(
  parameter int unsigned RAM_SIZE    = DEF_RAM_SIZE,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned NUM_BANKS   = DEF_NUM_BANKS,
  parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
  localparam int unsigned ADDR_WIDTH = $clog2(RAM_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic                      we_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic                      bypass_en_i,
  output logic                      rvalid_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic [NUM_BANKS-1:0]      bank_sleep_o
);

  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(BE_W);
  localparam int unsigned BANK_W = $clog2(NUM_BANKS);
  localparam int unsigned SEL_W  = width_of(NUM_BANKS);
  localparam int unsigned WORDS  = RAM_SIZE / BE_W / NUM_BANKS;
  localparam int unsigned IDX_W  = width_of(WORDS);

  logic [SEL_W-1:0]      bank_sel;
  logic [IDX_W-1:0]      word_idx;
  logic [NUM_BANKS-1:0]  bank_active_c;
  logic [NUM_BANKS-1:0]  bank_sleep_c;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic                  acc_c;
  logic [DATA_WIDTH-1:0] resp_c;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Banks are contiguous: the top address bits pick the bank
  if (BANK_W > 0) begin : g_sel
    assign bank_sel = addr_i[ADDR_WIDTH-1 -: BANK_W];
  end else begin : g_nosel
    assign bank_sel = '0;
  end

  if (OFF_W > 0) begin : g_off
    logic unused_off;
    assign unused_off = ^addr_i[OFF_W-1:0];
  end

  assign word_idx = addr_i[OFF_W +: IDX_W];

  assign gnt_o = req_i & ~rst_i & bank_active_c[bank_sel];
  assign acc_c = gnt_o;

  for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
    logic hit;
    assign hit = (bank_sel == SEL_W'(b));

    sp_ram_bank_pm #(
      .WORDS       (WORDS),
      .DATA_WIDTH  (DATA_WIDTH),
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_bank (
      .clk      (clk),
      .rst_i    (rst_i),
      .req_i    (req_i & ~rst_i & hit),
      .acc_i    (acc_c & hit),
      .we_i     (we_i),
      .be_i     (be_i),
      .word_i   (word_idx),
      .wdata_i  (wdata_i),
      .rdata_c  (bank_rdata[b]),
      .active_c (bank_active_c[b]),
      .sleep_c  (bank_sleep_c[b])
    );
  end

  // Writes answer with their own data only when bypass is requested
  always_comb begin
    resp_c = '0;
    if (we_i) begin
      if (bypass_en_i) resp_c = wdata_i;
    end else begin
      resp_c = bank_rdata[bank_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= acc_c;
      if (acc_c) rdata_q <= resp_c;
    end
  end

  // Outputs are forced low for the whole time reset is held
  assign rvalid_o     = rvalid_q & ~rst_i;
  assign rdata_o      = rst_i ? '0 : rdata_q;
  assign bank_sleep_o = bank_sleep_c & {NUM_BANKS{~rst_i}};

endmodule

// File: tb/tb_sp_ram_banked.sv
// Scoreboard bench for sp_ram_banked: directed accesses push expected responses,
// a negedge monitor pops and checks them; sleep checks adapt to SP_RAM_SLEEP_EN.
module tb_sp_ram_banked;

`ifdef SP_RAM_SLEEP_EN
  localparam bit SLP = 1'b1;
`else
  localparam bit SLP = 1'b0;
`endif
  localparam int WK = SLP ? 3 : 0;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        gnt_o;
  logic [14:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        bypass_en_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [7:0]  bank_sleep_o;

  typedef struct {
    logic [31:0] data;
    time         t;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] hold_exp = '0;
  int          tests = 0;
  int          fails = 0;

  sp_ram_banked dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .wdata_i      (wdata_i),
    .bypass_en_i  (bypass_en_i),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .bank_sleep_o (bank_sleep_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: response data, exact one-cycle latency, hold while idle, reset values
  always @(negedge clk) begin
    if (rst_i) begin
      check("reset_outputs", {22'd0, gnt_o, rvalid_o, rdata_o, bank_sleep_o}, 64'd0);
      hold_exp = '0;
    end else if (rvalid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 64'(rvalid_o), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rdata", 64'(rdata_o), 64'(e.data));
        check("rvalid_latency", 64'($time - e.t), 64'd5);
        hold_exp = e.data;
      end
    end else begin
      check("rdata_hold", 64'(rdata_o), 64'(hold_exp));
    end
  end

  // Issue one request starting just after a posedge; returns just after the accepting posedge
  task automatic access(input logic we, input logic [14:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic byp, input logic [31:0] exp,
                        input bit push, input int exp_wait);
    int waited = 0;
    bit granted = 1'b0;
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd; bypass_en_i = byp;
    forever begin
      @(negedge clk);
      granted = gnt_o;
      if (granted) break;
      waited++;
      if (waited > 20) break;
      @(posedge clk);
    end
    check("grant_wait", 64'(waited), 64'(exp_wait));
    @(posedge clk);
    if (granted && push) exp_q.push_back('{data: exp, t: $time});
    #1;
    req_i = 1'b0; we_i = 1'b0; be_i = '0; wdata_i = '0; bypass_en_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; req_i = 1'b1; addr_i = '0; we_i = 1'b0; be_i = '0;
    wdata_i = '0; bypass_en_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 req_i = 1'b0;
    @(posedge clk);
    #1 rst_i = 1'b0;

    // Bank 0 accessed exactly when its idle counter sits at 15
    repeat (15) @(posedge clk);
    #1;
    access(1'b1, 15'h0000, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 0);
    check("sleep_after_expiry", 64'(bank_sleep_o), SLP ? 64'hFE : 64'h0);

    access(1'b0, 15'h0000, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 0);

    // Byte-enable merge into a (possibly sleeping) bank 1
    access(1'b1, 15'h1004, 4'hF, 32'h11223344, 1'b0, 32'h0, 1'b1, WK);
    access(1'b1, 15'h1004, 4'h1, 32'h000000AA, 1'b0, 32'h0, 1'b1, 0);
    access(1'b0, 15'h1004, 4'h0, 32'h0, 1'b0, 32'h112233AA, 1'b1, 0);

    // Bypass on and off, then a write with no byte enables
    access(1'b1, 15'h1008, 4'hF, 32'h5A5A5A5A, 1'b1, 32'h5A5A5A5A, 1'b1, 0);
    access(1'b1, 15'h1008, 4'hF, 32'h5A5A5A5A, 1'b0, 32'h0, 1'b1, 0);
    access(1'b1, 15'h1004, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1, 0);
    access(1'b0, 15'h1004, 4'h0, 32'h0, 1'b0, 32'h112233AA, 1'b1, 0);
    access(1'b0, 15'h1008, 4'h0, 32'h0, 1'b0, 32'h5A5A5A5A, 1'b1, 0);

    // Bank 3: sleeps after 16 idle cycles, wakes on demand, keeps data
    access(1'b1, 15'h3000, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1, WK);
    repeat (15) @(posedge clk);
    #1 check("bank3_awake_at_15", 64'(bank_sleep_o[3]), 64'd0);
    @(posedge clk);
    #1 check("bank3_asleep_at_16", 64'(bank_sleep_o[3]), 64'(SLP));
    access(1'b0, 15'h3000, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1, WK);

    // Reset the cycle after an accepted read: response must be dropped
    access(1'b0, 15'h3000, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("no_rvalid_after_reset", 64'(rvalid_o), 64'd0);
    @(posedge clk);
    #1;
    access(1'b0, 15'h0000, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 0);
    access(1'b0, 15'h1004, 4'h0, 32'h0, 1'b0, 32'h112233AA, 1'b1, 0);
    access(1'b0, 15'h3000, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
